// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point FFT: frame geometry, sample type, loader states and the
// index bit-reversal used by both the input loader and the butterfly core.
package fft_pkg;

  localparam int unsigned D_WIDTH     = 64;
  localparam int unsigned LOG_2_WIDTH = 6;
  localparam int unsigned FFT_CYCLES  = 192;

  typedef logic [15:0] sample_t;

  typedef enum logic [1:0] {
    FILL,
    LAUNCH,
    WAIT
  } loader_state_e;

  function automatic logic [LOG_2_WIDTH-1:0] bitrev(input logic [LOG_2_WIDTH-1:0] idx);
    logic [LOG_2_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LOG_2_WIDTH; i++) begin
      r[i] = idx[LOG_2_WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_reverse_index.sv
// Combinational reverser: output bit i is input bit Width-1-i.
module bit_reverse_index #(
  parameter int unsigned Width = 6
) (
  input  logic [Width-1:0] idx_i,
  output logic [Width-1:0] idx_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < Width; i++) begin
      idx_o[i] = idx_i[Width-1-i];
    end
  end

endmodule

// File: rtl/fft_input_loader.sv
// Collects one frame of complex samples into a bit-reversed buffer, launches the butterfly core
// and then blocks input until the core's compute window has elapsed.
module fft_input_loader #(
  parameter int unsigned D_WIDTH     = fft_pkg::D_WIDTH,
  parameter int unsigned LOG_2_WIDTH = fft_pkg::LOG_2_WIDTH,
  parameter int unsigned FFT_CYCLES  = fft_pkg::FFT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  fft_pkg::sample_t     in_Re,
  input  fft_pkg::sample_t     in_Im,
  output fft_pkg::sample_t     output_Re [D_WIDTH],
  output fft_pkg::sample_t     output_Im [D_WIDTH],
  output logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  output logic [LOG_2_WIDTH:0] fill_count
);

  import fft_pkg::*;

  localparam int unsigned CntW = (FFT_CYCLES > 1) ? $clog2(FFT_CYCLES) : 1;
  localparam logic [LOG_2_WIDTH:0] LastIdx = (LOG_2_WIDTH + 1)'(D_WIDTH - 1);
  localparam logic [CntW-1:0] WaitLoad = CntW'(FFT_CYCLES - 1);

  loader_state_e          state_q, state_d;
  logic [LOG_2_WIDTH:0]   count_q, count_d;
  logic [CntW-1:0]        wait_q, wait_d;
  sample_t                re_q [D_WIDTH];
  sample_t                im_q [D_WIDTH];
  logic [LOG_2_WIDTH-1:0] wr_addr;
  logic                   accept;

  bit_reverse_index #(
    .Width (LOG_2_WIDTH)
  ) u_rev (
    .idx_i (count_q[LOG_2_WIDTH-1:0]),
    .idx_o (wr_addr)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wait_d     = wait_q;
    in_ready   = 1'b0;
    start      = 1'b0;
    frame_done = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      FILL: begin
        in_ready = ~rst;
        accept   = in_valid & ~rst;
        if (accept) begin
          count_d = count_q + 1'b1;
          if (count_q == LastIdx) begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        start   = ~rst;
        wait_d  = WaitLoad;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == '0) begin
          frame_done = ~rst;
          count_d    = '0;
          state_d    = FILL;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wait_q  <= wait_d;
    end
  end

  // Buffer is only written during FILL, so the frame stays stable for the core until refilled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D_WIDTH; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (accept) begin
      re_q[wr_addr] <= in_Re;
      im_q[wr_addr] <= in_Im;
    end
  end

  assign busy       = (state_q != FILL);
  assign fill_count = count_q;
  assign output_Re  = re_q;
  assign output_Im  = im_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Scenario bench for fft_input_loader: default build plus an FFT_CYCLES = 1 build.
module tb_fft_input_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default build
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_re = '0, in_im = '0;
  logic        in_ready, start, busy, frame_done;
  logic [6:0]  fill_count;
  logic [15:0] out_re [64];
  logic [15:0] out_im [64];

  // FFT_CYCLES = 1 build
  logic        rst1 = 1'b1;
  logic        valid1 = 1'b0;
  logic [15:0] re1 = '0, im1 = '0;
  logic        in_ready1, start1, busy1, frame_done1;
  logic [6:0]  fill_count1;
  logic [15:0] out_re1 [64];
  logic [15:0] out_im1 [64];

  fft_input_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_Re      (in_re),
    .in_Im      (in_im),
    .output_Re  (out_re),
    .output_Im  (out_im),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .fill_count (fill_count)
  );

  fft_input_loader #(
    .FFT_CYCLES (1)
  ) dut1 (
    .clk        (clk),
    .rst        (rst1),
    .in_valid   (valid1),
    .in_ready   (in_ready1),
    .in_Re      (re1),
    .in_Im      (im1),
    .output_Re  (out_re1),
    .output_Im  (out_im1),
    .start      (start1),
    .busy       (busy1),
    .frame_done (frame_done1),
    .fill_count (fill_count1)
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   n_acc;

  function automatic int rev6(input int i);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) begin
      if (((i >> b) & 1) != 0) r = r | (1 << (5 - b));
    end
    return r;
  endfunction

  function automatic logic [15:0] neg16(input int v);
    return 16'(0 - v);
  endfunction

  // Called at a falling edge: drive one cycle, scoreboard any accepted sample.
  task automatic step(input logic v, input logic [15:0] re, input logic [15:0] im,
                      output logic acc);
    exp_t e;
    in_valid = v;
    in_re    = re;
    in_im    = im;
    acc      = v && in_ready;
    if (acc) begin
      e.addr = 6'(rev6(n_acc));
      e.re   = re;
      e.im   = im;
      sb_q.push_back(e);
      n_acc = (n_acc == 63) ? 0 : n_acc + 1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (acc) begin
      e = sb_q.pop_front();
      checks++;
      if (out_re[e.addr] !== e.re || out_im[e.addr] !== e.im) begin
        errors++;
        $display("FAIL write[%0d]: got %h/%h expected %h/%h", e.addr, out_re[e.addr],
                 out_im[e.addr], e.re, e.im);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb_q.delete();
    n_acc = 0;
    cyc   = 1;
  endtask

  task automatic test_reset();
    int bad;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: got %b expected 0", in_ready);
    end
    checks++;
    if (start !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || fill_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b busy=%b done=%b fill=%0d expected 0 0 0 0",
               start, busy, frame_done, fill_count);
    end
    bad = 0;
    for (int k = 0; k < 64; k++) if (out_re[k] !== 16'h0 || out_im[k] !== 16'h0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_buffer: got %0d nonzero entries expected 0", bad);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", in_ready);
    end
  endtask

  // Continuous valid through fill, launch and the whole wait window.
  task automatic test_frame_timing();
    int n, first_start, start_cnt, fd_cyc, nready, nbusy, both, bad;
    logic ready_after, acc;
    logic [6:0] fc_launch, fc_after;
    logic [15:0] re;
    do_reset();
    n = 0; first_start = 0; start_cnt = 0; fd_cyc = 0; nready = 0; nbusy = 0; both = 0;
    ready_after = 1'b0; fc_launch = '0; fc_after = '1;
    for (int i = 0; i < 320; i++) begin
      if (fd_cyc != 0 && cyc == fd_cyc + 1) begin
        ready_after = in_ready;
        fc_after    = fill_count;
        break;
      end
      if (start) begin
        start_cnt++;
        if (first_start == 0) begin
          first_start = cyc;
          fc_launch   = fill_count;
        end
      end
      if (frame_done && fd_cyc == 0) fd_cyc = cyc;
      if (start && frame_done) both++;
      if (!in_ready) nready++;
      if (busy) nbusy++;
      re = (n < 64) ? 16'(n) : 16'h7777;
      step(1'b1, re, (n < 64) ? neg16(n) : 16'h7777, acc);
      if (acc) n++;
    end
    checks++;
    if (first_start != 65 || start_cnt != 1) begin
      errors++;
      $display("FAIL start_timing: got cycle %0d count %0d expected cycle 65 count 1",
               first_start, start_cnt);
    end
    checks++;
    if (fc_launch !== 7'd64) begin
      errors++;
      $display("FAIL fill_count_full: got %0d expected 64", fc_launch);
    end
    checks++;
    if (fd_cyc != 257) begin
      errors++;
      $display("FAIL frame_done_cycle: got %0d expected 257", fd_cyc);
    end
    checks++;
    if (nready != 193 || nbusy != 193) begin
      errors++;
      $display("FAIL blocked_window: got ready_low=%0d busy=%0d expected 193 193",
               nready, nbusy);
    end
    checks++;
    if (ready_after !== 1'b1 || fc_after !== 7'd0) begin
      errors++;
      $display("FAIL refill_ready: got ready=%b fill=%0d expected 1 0", ready_after, fc_after);
    end
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL start_and_done_overlap: got %0d expected 0", both);
    end
    checks++;
    if (out_re[32] !== 16'd1 || out_re[48] !== 16'd3 || out_im[24] !== 16'hFFFA) begin
      errors++;
      $display("FAIL bitrev_points: got %h %h %h expected 0001 0003 fffa",
               out_re[32], out_re[48], out_im[24]);
    end
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (out_re[rev6(k)] !== 16'(k) || out_im[rev6(k)] !== neg16(k)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_held: got %0d wrong entries expected 0", bad);
    end
  endtask

  task automatic test_toggle_valid();
    int n, last_acc, start_cyc, start_cnt, bad;
    logic acc, v;
    do_reset();
    n = 0; last_acc = 0; start_cyc = 0; start_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (n == 64 && cyc > last_acc + 2) break;
      v = (cyc % 2) == 1;
      step(v && n < 64, 16'(n), neg16(n), acc);
      if (acc) begin
        n++;
        if (n == 64) last_acc = cyc - 1;
      end
    end
    checks++;
    if (last_acc != 127 || start_cyc != last_acc + 1 || start_cnt != 1) begin
      errors++;
      $display("FAIL toggle_start: got last_acc=%0d start=%0d count=%0d expected 127 128 1",
               last_acc, start_cyc, start_cnt);
    end
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (out_re[rev6(k)] !== 16'(k) || out_im[rev6(k)] !== neg16(k)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL toggle_buffer: got %0d wrong entries expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, bad, spurious, events;
    logic acc;
    do_reset();
    for (int k = 0; k < 20; k++) step(1'b1, 16'h0100 + 16'(k), 16'h0500 + 16'(k), acc);
    do_reset();
    bad = 0;
    for (int k = 0; k < 64; k++) if (out_re[k] !== 16'h0 || out_im[k] !== 16'h0) bad++;
    checks++;
    if (bad != 0 || fill_count !== 7'd0) begin
      errors++;
      $display("FAIL midframe_reset: got %0d nonzero fill=%0d expected 0 0", bad, fill_count);
    end
    n = 0; spurious = 0;
    for (int i = 0; i < 100 && n < 64; i++) begin
      if (start) spurious++;
      step(1'b1, 16'h0200 + 16'(n), 16'h0600 + 16'(n), acc);
      if (acc) n++;
    end
    checks++;
    if (spurious != 0 || start !== 1'b1) begin
      errors++;
      $display("FAIL no_spurious_start: got early=%0d start=%b expected 0 1", spurious, start);
    end
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (out_re[rev6(k)] !== 16'h0200 + 16'(k) || out_im[rev6(k)] !== 16'h0600 + 16'(k))
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_frame: got %0d wrong entries expected 0", bad);
    end
    for (int k = 0; k < 10; k++) step(1'b0, '0, '0, acc);
    do_reset();
    events = 0;
    for (int k = 0; k < 300; k++) begin
      if (start || frame_done || busy) events++;
      step(1'b0, '0, '0, acc);
    end
    checks++;
    if (events != 0) begin
      errors++;
      $display("FAIL midwait_reset: got %0d start/done/busy cycles expected 0", events);
    end
  endtask

  task automatic test_back_to_back();
    int a, s1, s2, bad;
    logic acc;
    logic [15:0] re, im;
    do_reset();
    a = 0; s1 = 0; s2 = 0;
    for (int i = 0; i < 700; i++) begin
      if (start) begin
        if (s1 == 0) s1 = cyc;
        else if (s2 == 0) s2 = cyc;
      end
      if (s2 != 0) break;
      re = (a < 64) ? 16'h1000 + 16'(a) : 16'h3000 + 16'(a - 64);
      im = (a < 64) ? 16'h2000 + 16'(a) : 16'h4000 + 16'(a - 64);
      step(a < 128, re, im, acc);
      if (acc) a++;
    end
    checks++;
    if (s1 != 65 || s2 - s1 != 257) begin
      errors++;
      $display("FAIL b2b_period: got first=%0d gap=%0d expected 65 257", s1, s2 - s1);
    end
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (out_re[rev6(k)] !== 16'h3000 + 16'(k) || out_im[rev6(k)] !== 16'h4000 + 16'(k))
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_replace: got %0d stale entries expected 0", bad);
    end
  endtask

  task automatic test_fft_cycles_one();
    @(negedge clk);
    rst1   = 1'b1;
    valid1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      valid1 = 1'b1;
      re1    = 16'(k);
      im1    = neg16(k);
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (start1 !== 1'b1 || busy1 !== 1'b1 || in_ready1 !== 1'b0 || frame_done1 !== 1'b0) begin
      errors++;
      $display("FAIL c1_launch: got start=%b busy=%b ready=%b done=%b expected 1 1 0 0",
               start1, busy1, in_ready1, frame_done1);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (start1 !== 1'b0 || frame_done1 !== 1'b1 || in_ready1 !== 1'b0 || fill_count1 !== 7'd64)
    begin
      errors++;
      $display("FAIL c1_wait: got start=%b done=%b ready=%b fill=%0d expected 0 1 0 64",
               start1, frame_done1, in_ready1, fill_count1);
    end
    valid1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready1 !== 1'b1 || busy1 !== 1'b0 || frame_done1 !== 1'b0 || fill_count1 !== 7'd0)
    begin
      errors++;
      $display("FAIL c1_refill: got ready=%b busy=%b done=%b fill=%0d expected 1 0 0 0",
               in_ready1, busy1, frame_done1, fill_count1);
    end
    checks++;
    if (out_re1[32] !== 16'd1 || out_im1[24] !== 16'hFFFA) begin
      errors++;
      $display("FAIL c1_buffer: got %h %h expected 0001 fffa", out_re1[32], out_im1[24]);
    end
  endtask

  initial begin
    n_acc = 0;
    cyc   = 0;
    test_reset();
    test_frame_timing();
    test_toggle_valid();
    test_reset_mid_frame();
    test_back_to_back();
    test_fft_cycles_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
